midi_event_framer: RTL and testbench

- Converts the raw MIDI byte stream from the UART receiver into complete channel-voice events (command, param1, param2) for the voice allocator.
- Handles running status, filters realtime and system messages, and optionally filters by channel.
- Presents each event on a valid/ack handshake that holds the event until the consumer acknowledges it.
- Sits between the UART byte receiver and the note/controller processor.

---
 rtl/midi_defs.sv | 31 +++
 rtl/midi_event_framer_if.sv | 28 ++
 rtl/midi_event_holder.sv | 71 +++++++
 rtl/midi_event_framer.sv | 141 ++++++++++++++
 tb/tb_midi_event_framer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/midi_defs.sv
// Shared MIDI constants and helpers for the event framer.
// Status nibbles, system byte codes and the per-status data-byte count.
package midi_defs;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] TUNE_REQ     = 8'hF6;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  // Data bytes that follow a channel-voice status byte (0 for system).
  function automatic logic [1:0] data_bytes(input logic [7:0] status);
    logic [1:0] n;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: n = 2'd2;
      PROG, CHAN_AT:                         n = 2'd1;
      SYS:                                   n = 2'd0;
      default:                               n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_event_framer_if.sv
// Byte-in / event-out bundle of the MIDI event framer.
// master = framer side, slave = byte source plus event consumer.
interface midi_event_framer_if #(
  parameter int OVERRUN_BITS = 8
);
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    midi_event_valid;
  logic [7:0]              midi_command;
  logic [6:0]              midi_parameter_1;
  logic [6:0]              midi_parameter_2;
  logic                    midi_event_ack;
  logic [OVERRUN_BITS-1:0] overrun_count;

  modport master (
    input  byte_valid, byte_data, midi_event_ack,
    output midi_event_valid, midi_command,
    output midi_parameter_1, midi_parameter_2,
    output overrun_count
  );

  modport slave (
    output byte_valid, byte_data, midi_event_ack,
    input  midi_event_valid, midi_command,
    input  midi_parameter_1, midi_parameter_2,
    input  overrun_count
  );
endinterface

// File: rtl/midi_event_holder.sv
// Output register for completed MIDI events with valid/ack handshake.
// A completion while an un-acked event is held is dropped and counted.
module midi_event_holder #(
  parameter int OVERRUN_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [7:0]              cmd_i,
  input  logic [6:0]              p1_i,
  input  logic [6:0]              p2_i,
  input  logic                    ack_i,
  output logic                    valid_o,
  output logic [7:0]              cmd_o,
  output logic [6:0]              p1_o,
  output logic [6:0]              p2_o,
  output logic [OVERRUN_BITS-1:0] overrun_o
);

  logic                    valid_q, valid_d;
  logic [7:0]              cmd_q, cmd_d;
  logic [6:0]              p1_q, p1_d;
  logic [6:0]              p2_q, p2_d;
  logic [OVERRUN_BITS-1:0] ovr_q, ovr_d;

  // Load when the slot is free or being retired this cycle; else drop.
  always_comb begin
    valid_d = valid_q;
    cmd_d   = cmd_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    ovr_d   = ovr_q;
    if (load_i && (!valid_q || ack_i)) begin
      valid_d = 1'b1;
      cmd_d   = cmd_i;
      p1_d    = p1_i;
      p2_d    = p2_i;
    end else begin
      if (load_i && (ovr_q != '1)) begin
        ovr_d = ovr_q + OVERRUN_BITS'(1);
      end
      if (valid_q && ack_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // Event and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      ovr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o   = valid_q;
  assign cmd_o     = cmd_q;
  assign p1_o      = p1_q;
  assign p2_o      = p2_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/midi_event_framer.sv
// MIDI byte stream to channel-voice event framer (running status, filters).
// Optional: MIDI_NOTE_ON_VEL0_AS_OFF_EN maps note-on vel 0 to note-off.
module midi_event_framer
  import midi_defs::*;
#(
  parameter bit         OMNI         = 1'b1,
  parameter logic [3:0] CHANNEL      = 4'd0,
  parameter int         OVERRUN_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  midi_event_framer_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_P1   = 2'd1;
  localparam logic [1:0] S_P2   = 2'd2;
  localparam logic [1:0] S_SKIP = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] rs_q, rs_d;
  logic [7:0] cmd_q, cmd_d;
  logic [6:0] p1_q, p1_d;

  logic       done;
  logic [7:0] ev_cmd;
  logic [6:0] ev_p1;
  logic [6:0] ev_p2;
  logic       load;
  logic [7:0] out_cmd;
  logic [6:0] out_p2;
  logic [7:0] b;

  assign b = bus.byte_data;

  // Parser: rs_q == 0 means no running status (real ones have bit 7).
  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    cmd_d   = cmd_q;
    p1_d    = p1_q;
    done    = 1'b0;
    ev_cmd  = cmd_q;
    ev_p1   = p1_q;
    ev_p2   = '0;
    if (bus.byte_valid && (b < REALTIME_MIN)) begin
      if (b[7]) begin
        if (b >= SYSEX_START) begin
          rs_d    = '0;
          state_d = (b == TUNE_REQ || b == SYSEX_END) ? S_IDLE : S_SKIP;
        end else begin
          rs_d    = b;
          cmd_d   = b;
          state_d = S_P1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rs_q[7]) begin
              cmd_d = rs_q;
              if (data_bytes(rs_q) == 2'd1) begin
                done   = 1'b1;
                ev_cmd = rs_q;
                ev_p1  = b[6:0];
              end else begin
                p1_d    = b[6:0];
                state_d = S_P2;
              end
            end
          end
          S_P1: begin
            if (data_bytes(cmd_q) == 2'd1) begin
              done    = 1'b1;
              ev_p1   = b[6:0];
              state_d = S_IDLE;
            end else begin
              p1_d    = b[6:0];
              state_d = S_P2;
            end
          end
          S_P2: begin
            done    = 1'b1;
            ev_p2   = b[6:0];
            state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign load = done && (OMNI || (ev_cmd[3:0] == CHANNEL));

`ifdef MIDI_NOTE_ON_VEL0_AS_OFF_EN
  // Present note-on with zero velocity as note-off, velocity 0x40.
  always_comb begin
    out_cmd = ev_cmd;
    out_p2  = ev_p2;
    if (ev_cmd[7:4] == NOTE_ON && ev_p2 == 7'd0) begin
      out_cmd = {NOTE_OFF, ev_cmd[3:0]};
      out_p2  = 7'h40;
    end
  end
`else
  assign out_cmd = ev_cmd;
  assign out_p2  = ev_p2;
`endif

  // Parser state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rs_q    <= '0;
      cmd_q   <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      cmd_q   <= cmd_d;
      p1_q    <= p1_d;
    end
  end

  midi_event_holder #(
    .OVERRUN_BITS(OVERRUN_BITS)
  ) u_holder (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .cmd_i     (out_cmd),
    .p1_i      (ev_p1),
    .p2_i      (out_p2),
    .ack_i     (bus.midi_event_ack),
    .valid_o   (bus.midi_event_valid),
    .cmd_o     (bus.midi_command),
    .p1_o      (bus.midi_parameter_1),
    .p2_o      (bus.midi_parameter_2),
    .overrun_o (bus.overrun_count)
  );

endmodule

// File: tb/tb_midi_event_framer.sv
// Testbench for midi_event_framer: omni instance A, channel-2 instance B.
// Expected events go into a queue at stimulus time and are popped on valid.
module tb_midi_event_framer;

  typedef struct packed {
    logic [7:0] c;
    logic [6:0] a;
    logic [6:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  ev_t  exp_ev;
  ev_t  held;
  ev_t  got;

  always #5 clk = ~clk;

  midi_event_framer_if #(.OVERRUN_BITS(8)) ia ();
  midi_event_framer_if #(.OVERRUN_BITS(8)) ib ();

  midi_event_framer #(
    .OMNI(1'b1), .CHANNEL(4'd0), .OVERRUN_BITS(8)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );

  midi_event_framer #(
    .OMNI(1'b0), .CHANNEL(4'd2), .OVERRUN_BITS(8)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  assign got = {ia.midi_command, ia.midi_parameter_1, ia.midi_parameter_2};

  task automatic send(input bit sel, input logic [7:0] v);
    @(negedge clk);
    if (sel) begin ib.byte_valid = 1'b1; ib.byte_data = v; end
    else begin ia.byte_valid = 1'b1; ia.byte_data = v; end
    @(negedge clk);
    ia.byte_valid = 1'b0;
    ib.byte_valid = 1'b0;
  endtask

  task automatic ack(input bit sel);
    @(negedge clk);
    if (sel) ib.midi_event_ack = 1'b1;
    else ia.midi_event_ack = 1'b1;
    @(negedge clk);
    ia.midi_event_ack = 1'b0;
    ib.midi_event_ack = 1'b0;
  endtask

  task automatic test_reset;
    ia.byte_valid = 0; ia.byte_data = 0; ia.midi_event_ack = 0;
    ib.byte_valid = 0; ib.byte_data = 0; ib.midi_event_ack = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ia.midi_event_valid, got, ia.overrun_count} !== '0) begin
      errors++;
      $display("FAIL reset_a got v=%b ev=%h ovr=%0d want 0",
               ia.midi_event_valid, got, ia.overrun_count);
    end
    checks++;
    if (ib.midi_event_valid !== 1'b0 || ib.overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_b got v=%b ovr=%0d want 0",
               ib.midi_event_valid, ib.overrun_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send(0, 8'h90);
    send(0, 8'h3C);
    checks++;
    if (ia.midi_event_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got valid=%b want 0", ia.midi_event_valid);
    end
    send(0, 8'h64);
    q.push_back('{8'h90, 7'h3C, 7'h64});
    checks++;
    if (ia.midi_event_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid got %b want 1", ia.midi_event_valid);
    end else begin
      exp_ev = q.pop_front();
      checks++;
      if (got !== exp_ev) begin
        errors++;
        $display("FAIL basic_event got %h want %h", got, exp_ev);
      end
    end
    ack(0);
    checks++;
    if (ia.midi_event_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack got valid=%b want 0", ia.midi_event_valid);
    end
  endtask

  task automatic test_running;
    logic [7:0] st[8] = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50,
                          8'hC2, 8'h05, 8'h00};
    int last[3] = '{2, 4, 6};
    ev_t e[3] = '{'{8'h90, 7'h3C, 7'h64},
                  '{8'h90, 7'h40, 7'h50},
                  '{8'hC2, 7'h05, 7'h00}};
    int k = 0;
    for (int i = 0; i < 7; i++) begin
      send(0, st[i]);
      if (k < 3 && i == last[k]) begin
        q.push_back(e[k]);
        checks++;
        if (ia.midi_event_valid !== 1'b1) begin
          errors++;
          $display("FAIL running_valid_%0d got 0 want 1", k);
          void'(q.pop_front());
        end else begin
          exp_ev = q.pop_front();
          checks++;
          if (got !== exp_ev) begin
            errors++;
            $display("FAIL running_event_%0d got %h want %h",
                     k, got, exp_ev);
          end
        end
        ack(0);
        k++;
      end
    end
  endtask

  task automatic test_realtime;
    logic [7:0] s1[5] = '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64};
    logic [7:0] s2[6] = '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h64};
    foreach (s1[i]) send(0, s1[i]);
    q.push_back('{8'h90, 7'h3C, 7'h64});
    exp_ev = q.pop_front();
    checks++;
    if (ia.midi_event_valid !== 1'b1 || got !== exp_ev) begin
      errors++;
      $display("FAIL realtime_event got v=%b %h want 1 %h",
               ia.midi_event_valid, got, exp_ev);
    end
    ack(0);
    foreach (s2[i]) send(0, s2[i]);
    checks++;
    if (ia.midi_event_valid !== 1'b0) begin
      errors++;
      $display("FAIL sysex_clears_rs got valid=%b want 0",
               ia.midi_event_valid);
    end
  endtask

  task automatic test_filter;
    send(1, 8'hB2); send(1, 8'h01); send(1, 8'h40);
    q.push_back('{8'hB2, 7'h01, 7'h40});
    exp_ev = q.pop_front();
    checks++;
    if (ib.midi_event_valid !== 1'b1 ||
        {ib.midi_command, ib.midi_parameter_1, ib.midi_parameter_2}
          !== exp_ev) begin
      errors++;
      $display("FAIL filter_pass got v=%b %h%h%h want 1 %h",
               ib.midi_event_valid, ib.midi_command,
               ib.midi_parameter_1, ib.midi_parameter_2, exp_ev);
    end
    ack(1);
    send(1, 8'hB3); send(1, 8'h01); send(1, 8'h40);
    checks++;
    if (ib.midi_event_valid !== 1'b0 || ib.overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL filter_drop got v=%b ovr=%0d want 0 0",
               ib.midi_event_valid, ib.overrun_count);
    end
  endtask

  task automatic test_vel0;
    send(0, 8'h91); send(0, 8'h3C); send(0, 8'h00);
`ifdef MIDI_NOTE_ON_VEL0_AS_OFF_EN
    q.push_back('{8'h81, 7'h3C, 7'h40});
`else
    q.push_back('{8'h91, 7'h3C, 7'h00});
`endif
    exp_ev = q.pop_front();
    checks++;
    if (ia.midi_event_valid !== 1'b1 || got !== exp_ev) begin
      errors++;
      $display("FAIL vel0 got v=%b %h want 1 %h",
               ia.midi_event_valid, got, exp_ev);
    end
    ack(0);
  endtask

  task automatic test_overrun;
    send(0, 8'h80); send(0, 8'h3C); send(0, 8'h00);
    q.push_back('{8'h80, 7'h3C, 7'h00});
    held = q.pop_front();
    send(0, 8'h80); send(0, 8'h3D); send(0, 8'h00);
    checks++;
    if (ia.midi_event_valid !== 1'b1 || got !== held) begin
      errors++;
      $display("FAIL overrun_hold got v=%b %h want 1 %h",
               ia.midi_event_valid, got, held);
    end
    checks++;
    if (ia.overrun_count !== 8'd1) begin
      errors++;
      $display("FAIL overrun_one got %0d want 1", ia.overrun_count);
    end
    send(0, 8'h80); send(0, 8'h3E);
    @(negedge clk);
    ia.byte_valid = 1'b1; ia.byte_data = 8'h11; ia.midi_event_ack = 1'b1;
    @(negedge clk);
    ia.byte_valid = 1'b0; ia.midi_event_ack = 1'b0;
    q.push_back('{8'h80, 7'h3E, 7'h11});
    held = q.pop_front();
    checks++;
    if (ia.midi_event_valid !== 1'b1 || got !== held ||
        ia.overrun_count !== 8'd1) begin
      errors++;
      $display("FAIL ack_coincide got v=%b %h ovr=%0d want 1 %h 1",
               ia.midi_event_valid, got, ia.overrun_count, held);
    end
    for (int i = 0; i < 300; i++) begin
      send(0, 8'h3C);
      send(0, 8'h01);
    end
    checks++;
    if (ia.overrun_count !== 8'd255) begin
      errors++;
      $display("FAIL overrun_sat got %0d want 255", ia.overrun_count);
    end
    checks++;
    if (ia.midi_event_valid !== 1'b1 || got !== held) begin
      errors++;
      $display("FAIL overrun_sat_hold got v=%b %h want 1 %h",
               ia.midi_event_valid, got, held);
    end
  endtask

  task automatic test_reset_mid;
    send(0, 8'h90); send(0, 8'h3C);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({ia.midi_event_valid, got, ia.overrun_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid got v=%b ev=%h ovr=%0d want 0",
               ia.midi_event_valid, got, ia.overrun_count);
    end
    @(negedge clk);
    rst = 1'b0;
    send(0, 8'h64);
    checks++;
    if (ia.midi_event_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_tail got valid=%b want 0",
               ia.midi_event_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_running();
    test_realtime();
    test_filter();
    test_vel0();
    test_overrun();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
